// File: rtl/score_hex_display.sv
// score_hex_display: signed score to active-low 7-seg HEX bank via iterative double-dabble.
// Optional HEX_SCORE_BLINK_EN adds a blink/overflow flash driven by a free-running divider.
module score_hex_display #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_W      = 20,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [BIN_W-1:0]        value,
  input  logic                    load,
  input  logic                    blink,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] hex_seg
);
  localparam int BCD_D = (BIN_W + 2) / 3;
  localparam int EXT_D = BCD_D > NUM_DIGITS ? BCD_D : NUM_DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, FORMAT = 2'd2;
  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic                    sign;
  logic [BIN_W-1:0]        mag;
  logic [4*BCD_D-1:0]      bcd, adj;
  logic [4*EXT_D-1:0]      bcd_ext;
  logic [8*NUM_DIGITS-1:0] seg_r, img;
  logic                    ovf;
  int                      msd;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign busy    = state != IDLE;
  assign bcd_ext = (4*EXT_D)'(bcd);

  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_D; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  // The minus sign steals one digit, so overflow is judged against the digits left for magnitude.
  always_comb begin
    ovf = 1'b0;
    msd = 0;
    img = '1;
    for (int i = 0; i < EXT_D; i++)
      if (bcd_ext[4*i +: 4] != 4'd0) begin
        msd = i;
        if (i >= NUM_DIGITS - int'(sign)) ovf = 1'b1;
      end
    for (int i = 0; i < NUM_DIGITS; i++)
      img[8*i +: 8] = ovf ? 8'hBF : i <= msd ? seg7(bcd_ext[4*i +: 4]) :
                      (sign && i == msd + 1) ? 8'hBF : 8'hFF;
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sign     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      seg_r    <= '1;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= state == FORMAT;
      if (state == IDLE && load) begin
        sign  <= value[BIN_W-1];
        mag   <= value[BIN_W-1] ? -value : value;
        bcd   <= '0;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        {bcd, mag} <= {adj, mag} << 1;
        cnt        <= cnt + 1'b1;
        if (cnt == CW'(BIN_W - 1)) state <= FORMAT;
      end else if (state == FORMAT) begin
        seg_r    <= img;
        overflow <= ovf;
        state    <= IDLE;
      end
    end

`ifdef HEX_SCORE_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] bcnt;
  logic          phase;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= !phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  assign hex_seg = ((blink | overflow) && !phase) ? '1 : seg_r;
`else
  localparam int unused_div = BLINK_DIV;
  logic unused_blink;
  assign unused_blink = blink;
  assign hex_seg      = seg_r;
`endif
endmodule
